// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory, and hands
// PC-tagged code words to the decoder through a valid/ready port with a one-entry skid.
module fetch_unit #(
  parameter int                 PC_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter int                 INSN_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] code,
  output logic [PC_W-1:0]   code_pc,
  output logic              code_valid,
  input  logic              code_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                imem_req_q, imem_req_d;
  logic [PC_W-1:0]     imem_addr_q, imem_addr_d;
  logic [INSN_W-1:0]   code_q, code_d;
  logic [PC_W-1:0]     code_pc_q, code_pc_d;
  logic                code_valid_q, code_valid_d;
  logic [INSN_W-1:0]   skid_q, skid_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic                skid_valid_q, skid_valid_d;

  logic                ack_ok;
  logic                transfer;
  logic                slot_free;
  logic [PC_W-1:0]     pc_inc;

  // An ack is only meaningful while our own request is outstanding.
  assign ack_ok    = imem_ack & imem_req_q;
  assign transfer  = code_valid_q & code_ready;
  assign slot_free = ~code_valid_q | code_ready;
  assign pc_inc    = pc_q + PC_ONE;

  // NOTE: every variable gets a default at the top of the always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    code_d       = code_q;
    code_pc_d    = code_pc_q;
    code_valid_d = code_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (transfer) begin
      code_valid_d = 1'b0;
    end

    if (redirect) begin
      // The in-flight ack and any buffered words belong to the abandoned path.
      pc_d         = redirect_pc;
      imem_addr_d  = redirect_pc;
      code_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (halt) begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end else begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt) begin
            state_d     = FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
          end
        end

        FETCH: begin
          if (ack_ok) begin
            pc_d        = pc_inc;
            imem_addr_d = pc_inc;
            if (slot_free) begin
              code_d       = imem_rdata;
              code_pc_d    = pc_q;
              code_valid_d = 1'b1;
              if (halt) begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
              end
            end else begin
              // Decoder stalled with a word already presented: park this one.
              skid_d       = imem_rdata;
              skid_pc_d    = pc_q;
              skid_valid_d = 1'b1;
              imem_req_d   = 1'b0;
              state_d      = HOLD;
            end
          end else if (halt) begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
          end
        end

        HOLD: begin
          if (code_ready) begin
            code_d       = skid_q;
            code_pc_d    = skid_pc_q;
            code_valid_d = 1'b1;
            skid_valid_d = 1'b0;
            if (halt) begin
              state_d    = IDLE;
              imem_req_d = 1'b0;
            end else begin
              state_d     = FETCH;
              imem_req_d  = 1'b1;
              imem_addr_d = pc_q;
            end
          end
        end

        default: begin
          state_d    = IDLE;
          imem_req_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      code_q       <= '0;
      code_pc_q    <= '0;
      code_valid_q <= 1'b0;
      // NOTE: the skid storage is a plain register, not a memory array, so it is
      // cleared with the rest of the state at no cost.
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      code_q       <= code_d;
      code_pc_q    <= code_pc_d;
      code_valid_q <= code_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign code       = code_q;
  assign code_pc    = code_pc_q;
  assign code_valid = code_valid_q;

  // Structural invariants of the skid and request logic.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!skid_valid_q || code_valid_q)
        else $error("fetch_unit: skid holds a word while the output slot is empty");
      assert (state_q == FETCH || !imem_req_q)
        else $error("fetch_unit: request raised outside FETCH");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with programmable
// ack latency and an in-order scoreboard of expected code_pc values.
module tb_fetch_unit;

  localparam int          PC_W      = 16;
  localparam int          INSN_W    = 32;
  localparam logic [31:0] WORD_BASE = 32'hA000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;
  logic [INSN_W-1:0] code;
  logic [PC_W-1:0]   code_pc;
  logic              code_valid;
  logic              code_ready = 1'b1;
  logic              redirect = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              halt = 1'b0;

  int                total = 0;
  int                bad = 0;
  logic [PC_W-1:0]   sb_q[$];

  int                lat = 0;
  logic              ack_force = 1'b0;
  int                wait_cnt;

  fetch_unit #(
    .PC_W    (PC_W),
    .RESET_PC('0),
    .INSN_W  (INSN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .code       (code),
    .code_pc    (code_pc),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  // Stateless memory: word = address + base; ack after `lat` waiting cycles.
  assign imem_ack   = ack_force | (imem_req && (wait_cnt >= lat));
  assign imem_rdata = WORD_BASE + {16'h0000, imem_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= 0;
    else if (imem_req && !imem_ack)  wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [PC_W-1:0] start, input int n);
    logic [PC_W-1:0] p;
    p = start;
    repeat (n) begin
      sb_q.push_back(p);
      p = p + 16'd1;
    end
  endtask

  task automatic trim_sb(input int keep);
    while (sb_q.size() > keep) void'(sb_q.pop_back());
  endtask

  // Scoreboard: every completed transfer must match the next expected PC and word.
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      logic [PC_W-1:0] exp_pc;
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected: observed code_pc=%h expected no transfer", code_pc);
      end
      if (sb_q.size() != 0) begin
        exp_pc = sb_q.pop_front();
        check("sb_code_pc", {16'h0000, code_pc}, {16'h0000, exp_pc});
        check("sb_code", code, WORD_BASE + {16'h0000, exp_pc});
      end
    end
  end

  initial begin
    // Reset values
    tick(3);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_imem_addr", {16'h0, imem_addr}, 32'd0);
    check("rst_code", code, 32'd0);
    check("rst_code_pc", {16'h0, code_pc}, 32'd0);
    check("rst_code_valid", {31'b0, code_valid}, 32'd0);

    // 1: zero-wait streaming, first word two cycles after release
    push_run(16'h0000, 40);
    rst_n = 1'b1;
    tick(2);
    check("t1_valid0", {31'b0, code_valid}, 32'd1);
    check("t1_pc0", {16'h0, code_pc}, 32'd0);
    check("t1_code0", code, 32'hA000_0000);
    tick(1);
    check("t1_pc1", {16'h0, code_pc}, 32'd1);
    tick(1);
    check("t1_pc2", {16'h0, code_pc}, 32'd2);
    tick(1);
    check("t1_pc3", {16'h0, code_pc}, 32'd3);

    // 2: five-cycle stall parks one word and drops the request
    code_ready = 1'b0;
    tick(1);
    check("t2_req_drop", {31'b0, imem_req}, 32'd0);
    tick(4);
    check("t2_req_held", {31'b0, imem_req}, 32'd0);
    check("t2_pc_stable", {16'h0, code_pc}, 32'd3);
    check("t2_code_stable", code, 32'hA000_0003);
    code_ready = 1'b1;
    tick(1);
    check("t2_skid_out", {16'h0, code_pc}, 32'd4);
    check("t2_req_back", {31'b0, imem_req}, 32'd1);
    check("t2_addr_back", {16'h0, imem_addr}, 32'd5);

    // 3: three-cycle ack latency, one word per four cycles
    lat = 3;
    tick(1);
    check("t3_valid_gap", {31'b0, code_valid}, 32'd0);
    check("t3_addr_w0", {16'h0, imem_addr}, 32'd5);
    tick(2);
    check("t3_addr_w2", {16'h0, imem_addr}, 32'd5);
    check("t3_valid_w2", {31'b0, code_valid}, 32'd0);
    tick(1);
    check("t3_valid_5", {31'b0, code_valid}, 32'd1);
    check("t3_pc_5", {16'h0, code_pc}, 32'd5);
    tick(1);
    check("t3_valid_drop", {31'b0, code_valid}, 32'd0);
    check("t3_addr_6", {16'h0, imem_addr}, 32'd6);
    tick(3);
    check("t3_valid_6", {31'b0, code_valid}, 32'd1);
    check("t3_pc_6", {16'h0, code_pc}, 32'd6);

    // 5: halt mid-stream, the acked word is delivered, then resume sequentially
    lat = 0;
    tick(2);
    check("t5_pc_8", {16'h0, code_pc}, 32'd8);
    halt = 1'b1;
    tick(1);
    check("t5_req_off", {31'b0, imem_req}, 32'd0);
    check("t5_last_pc", {16'h0, code_pc}, 32'd9);
    check("t5_last_valid", {31'b0, code_valid}, 32'd1);
    tick(2);
    check("t5_drained", {31'b0, code_valid}, 32'd0);
    check("t5_req_idle", {31'b0, imem_req}, 32'd0);
    halt = 1'b0;
    tick(1);
    check("t5_req_resume", {31'b0, imem_req}, 32'd1);
    check("t5_addr_resume", {16'h0, imem_addr}, 32'd10);
    tick(1);
    check("t5_pc_10", {16'h0, code_pc}, 32'd10);

    // 4: redirect while the skid is full and ack is forced high
    code_ready = 1'b0;
    tick(1);
    check("t4_hold_req", {31'b0, imem_req}, 32'd0);
    check("t4_hold_pc", {16'h0, code_pc}, 32'd10);
    trim_sb(0);
    push_run(16'h0040, 8);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    ack_force   = 1'b1;
    tick(1);
    check("t4_valid_clr", {31'b0, code_valid}, 32'd0);
    check("t4_addr", {16'h0, imem_addr}, 32'h40);
    check("t4_req", {31'b0, imem_req}, 32'd1);
    redirect   = 1'b0;
    ack_force  = 1'b0;
    code_ready = 1'b1;
    tick(1);
    check("t4_pc_40", {16'h0, code_pc}, 32'h40);
    check("t4_code_40", code, 32'hA000_0040);

    // 6: PC wrap; the 0x40 transfer in the redirect cycle still counts
    trim_sb(1);
    push_run(16'hFFFE, 8);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick(1);
    check("t6_valid_clr", {31'b0, code_valid}, 32'd0);
    check("t6_addr", {16'h0, imem_addr}, 32'hFFFE);
    redirect = 1'b0;
    tick(1);
    check("t6_pc_fffe", {16'h0, code_pc}, 32'hFFFE);
    tick(1);
    check("t6_pc_ffff", {16'h0, code_pc}, 32'hFFFF);
    check("t6_code_ffff", code, 32'hA000_FFFF);
    tick(1);
    check("t6_pc_wrap", {16'h0, code_pc}, 32'h0000);
    check("t6_code_wrap", code, 32'hA000_0000);

    // 6: reset asserted while waiting on a slow ack
    lat = 3;
    code_ready = 1'b0;
    tick(1);
    check("t6_wait_req", {31'b0, imem_req}, 32'd1);
    check("t6_wait_addr", {16'h0, imem_addr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_addr", {16'h0, imem_addr}, 32'd0);
    check("t6_rst_code", code, 32'd0);
    check("t6_rst_code_pc", {16'h0, code_pc}, 32'd0);
    check("t6_rst_valid", {31'b0, code_valid}, 32'd0);
    trim_sb(0);
    tick(2);

    push_run(16'h0000, 8);
    rst_n      = 1'b1;
    lat        = 0;
    code_ready = 1'b1;
    tick(2);
    check("t6_restart_valid", {31'b0, code_valid}, 32'd1);
    check("t6_restart_pc", {16'h0, code_pc}, 32'd0);
    halt = 1'b1;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
